// File: rtl/abs_negate_pipe.sv
// abs_negate_pipe: pipelined conditional-negate / absolute-value unit.
// Modes: 0 pass, 1 absolute, 2 negate, 3 sign-magnitude to two's complement.
// STAGES register stages with valid/ready handshake and per-stage stall;
// bubbles collapse. Overflow (most-negative input in mode 1/2) is flagged
// and counted on delivery in a saturating counter.
// Optional feature macro: ABS_SAT_EN -- overflow beats saturate to the most
// positive value with cout forced to 0 instead of wrapping.
module abs_negate_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sign,
  output logic             out_cout,
  output logic             out_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);

  logic [WIDTH-1:0] s0_d;
  logic [WIDTH-1:0] s0_res;
  logic [WIDTH:0]   s0_sum;
  logic             s0_x;
  logic             s0_cout;
  logic             s0_ovf;

  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] st_s;
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_o;
  logic [WIDTH-1:0]  st_d [STAGES];
  logic [STAGES-1:0] ld;
  logic [CNT_W-1:0]  cnt;

  // Stage 0 arithmetic: conditional one's complement plus carry-in X.
  always_comb begin
    s0_d = in_data;
    s0_x = 1'b0;
    case (in_mode)
      2'd0: s0_x = 1'b0;
      2'd1: s0_x = in_data[WIDTH-1];
      2'd2: s0_x = 1'b1;
      default: begin
        s0_d = {1'b0, in_data[WIDTH-2:0]};
        s0_x = in_data[WIDTH-1];
      end
    endcase
    s0_sum  = {1'b0, s0_d ^ {WIDTH{s0_x}}} + {{WIDTH{1'b0}}, s0_x};
    s0_res  = s0_sum[WIDTH-1:0];
    s0_cout = s0_sum[WIDTH];
    s0_ovf  = ((in_mode == 2'd1) || (in_mode == 2'd2)) &&
              (in_data == {1'b1, {(WIDTH-1){1'b0}}});
    if (s0_ovf) begin
`ifdef ABS_SAT_EN
      s0_res  = {1'b0, {(WIDTH-1){1'b1}}};
      s0_cout = 1'b0;
`else
      s0_res  = in_data;
`endif
    end
  end

  // Load enables: a stage advances when empty or when its successor advances.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = ~st_v[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      ld[i] = ~st_v[i] | ld[i+1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             up_v, up_s, up_c, up_o;
    logic [WIDTH-1:0] up_d;
    logic             r_v, r_s, r_c, r_o;
    logic [WIDTH-1:0] r_d;

    if (g == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = s0_res;
      assign up_s = in_data[WIDTH-1];
      assign up_c = s0_cout;
      assign up_o = s0_ovf;
    end else begin : g_body
      assign up_v = st_v[g-1];
      assign up_d = st_d[g-1];
      assign up_s = st_s[g-1];
      assign up_c = st_c[g-1];
      assign up_o = st_o[g-1];
    end

    // Stage register: payload only captured with a valid beat so idle stages hold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_d <= '0;
        r_s <= 1'b0;
        r_c <= 1'b0;
        r_o <= 1'b0;
      end else if (ld[g]) begin
        r_v <= up_v;
        if (up_v) begin
          r_d <= up_d;
          r_s <= up_s;
          r_c <= up_c;
          r_o <= up_o;
        end
      end
    end

    assign st_v[g] = r_v;
    assign st_d[g] = r_d;
    assign st_s[g] = r_s;
    assign st_c[g] = r_c;
    assign st_o[g] = r_o;
  end

  // Saturating overflow counter; clear wins over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (out_valid && out_ready && out_ovf && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = st_v[STAGES-1];
  assign out_data  = st_d[STAGES-1];
  assign out_sign  = st_s[STAGES-1];
  assign out_cout  = st_c[STAGES-1];
  assign out_ovf   = st_o[STAGES-1];
  assign ovf_count = cnt;

endmodule

// File: tb/tb_abs_negate_pipe.sv
// Testbench for abs_negate_pipe (WIDTH=16, STAGES=2): directed cases with
// literal expectations plus a randomized phase, all checked against a
// queue-based reference model sampled on the falling clock edge.
module tb_abs_negate_pipe;
  localparam int W  = 16;
  localparam int ST = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sign;
  logic          out_cout;
  logic          out_ovf;
  logic          cnt_clr;
  logic [CW-1:0] ovf_count;

  int checks = 0;
  int errors = 0;

  abs_negate_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sign(out_sign), .out_cout(out_cout), .out_ovf(out_ovf),
    .cnt_clr(cnt_clr), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    logic         c;
    logic         o;
    int           acc;
  } beat_t;

  beat_t q[$];
  int    mcnt = 0;
  int    cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain two's-complement arithmetic on unsigned integers.
  function automatic beat_t ref_beat(input logic [1:0] m, input logic [W-1:0] x);
    beat_t       b;
    int unsigned xi, mag, full;
    xi   = x;
    full = 1 << W;
    mag  = xi & ((full >> 1) - 1);
    b.s = x[W-1];
    b.c = 1'b0;
    b.o = 1'b0;
    b.d = x;
    b.acc = 0;
    case (m)
      2'd0: b.d = x;
      2'd1: if (x[W-1]) b.d = W'(full - xi);
      2'd2: begin b.d = W'(full - xi); b.c = (xi == 0); end
      default: begin
        if (x[W-1]) begin b.d = W'(full - mag); b.c = (mag == 0); end
        else b.d = W'(mag);
      end
    endcase
    if ((m == 2'd1 || m == 2'd2) && xi == (full >> 1)) begin
      b.o = 1'b1;
      b.c = 1'b0;
`ifdef ABS_SAT_EN
      b.d = W'((full >> 1) - 1);
`else
      b.d = x;
`endif
    end
    return b;
  endfunction

  // Compare process: signals are stable here and describe the next rising edge.
  always @(negedge clk) begin
    beat_t b, h;
    logic  dov;
    dov = 1'b0;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      chk("in_ready", in_ready, out_ready || (q.size() < ST));
      chk("out_valid", out_valid, (q.size() > 0) && ((cyc - q[0].acc) >= ST));
      chk("ovf_count", ovf_count, mcnt);
      if (out_valid && out_ready && q.size() > 0) begin
        h = q.pop_front();
        chk("out_beat", {out_data, out_sign, out_cout, out_ovf}, {h.d, h.s, h.c, h.o});
        dov = h.o;
      end
      if (cnt_clr) mcnt = 0;
      else if (dov && mcnt != (1 << CW) - 1) mcnt++;
      if (in_valid && in_ready) begin
        b = ref_beat(in_mode, in_data);
        b.acc = cyc;
        q.push_back(b);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] d);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] d, input logic s,
                         input logic c, input logic o);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk(name, {out_data, out_sign, out_cout, out_ovf}, {d, s, c, o});
  endtask

  logic [W-1:0] beats [6];
  logic [W-1:0] ovf_res;
  int           idx;
  logic         acc;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef ABS_SAT_EN
    ovf_res = 16'h7FFF;
`else
    ovf_res = 16'h8000;
`endif
    rst = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
    drive(1'b0, 2'd0, '0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_fields", {out_data, out_sign, out_cout, out_ovf}, '0);
    chk("rst_ovf_count", ovf_count, '0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Absolute value of -5, latency of two cycles.
    tick();
    drive(1'b1, 2'd1, 16'hFFFB);
    tick(); drive(1'b0, 2'd0, '0);
    chk("lat_not_early", out_valid, 1'b0);
    tick();
    chk_out("abs_m5", 16'h0005, 1'b1, 1'b0, 1'b0);

    // Negate zero then pass, back to back.
    tick();
    drive(1'b1, 2'd2, 16'h0000);
    tick(); drive(1'b1, 2'd0, 16'h1234);
    tick(); drive(1'b0, 2'd0, '0);
    chk_out("neg_zero", 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("pass_1234", 16'h1234, 1'b0, 1'b0, 1'b0);

    // Most-negative overflow, counting and clear priority.
    tick();
    drive(1'b1, 2'd1, 16'h8000);
    tick(); drive(1'b0, 2'd0, '0);
    tick();
    chk_out("abs_ovf", ovf_res, 1'b1, 1'b0, 1'b1);
    tick();
    chk("ovf_count_1", ovf_count, 16'd1);
    drive(1'b1, 2'd2, 16'h8000);
    tick(); drive(1'b0, 2'd0, '0);
    tick();
    chk_out("neg_ovf", ovf_res, 1'b1, 1'b0, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("ovf_clr_prio", ovf_count, 16'd0);

    // Sign-magnitude conversion including negative zero.
    drive(1'b1, 2'd3, 16'h8003);
    tick(); drive(1'b1, 2'd3, 16'h8000);
    tick(); drive(1'b0, 2'd0, '0);
    chk_out("sm_m3", 16'hFFFD, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("sm_negzero", 16'h0000, 1'b1, 1'b1, 1'b0);
    tick(); tick();

    // Stall: downstream blocked for four cycles while six beats stream in.
    beats[0] = 16'h0101; beats[1] = 16'h0202; beats[2] = 16'h0303;
    beats[3] = 16'h0404; beats[4] = 16'h0505; beats[5] = 16'h0606;
    idx = 0;
    for (int c = 0; c < 11; c++) begin
      out_ready = (c >= 4);
      if (idx < 6) drive(1'b1, 2'd0, beats[idx]);
      else drive(1'b0, 2'd0, '0);
      #1;
      if (c == 2 || c == 3) begin
        chk("stall_in_ready", in_ready, 1'b0);
        chk_out("stall_hold", beats[0], 1'b0, 1'b0, 1'b0);
      end
      if (c >= 4 && c <= 9) chk_out("stall_drain", beats[c-4], 1'b0, 1'b0, 1'b0);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    chk("stall_all_accepted", idx, 6);
    drive(1'b0, 2'd0, '0);
    out_ready = 1'b1;
    tick(); tick();

    // Reset with beats in flight.
    drive(1'b1, 2'd1, 16'h8000);
    tick(); drive(1'b1, 2'd0, 16'h0011);
    tick(); drive(1'b1, 2'd0, 16'h0022);
    tick(); drive(1'b0, 2'd0, '0);
    chk("pre_rst_count", ovf_count, 16'd1);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_count", ovf_count, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    drive(1'b1, 2'd0, 16'h00AA);
    tick(); drive(1'b0, 2'd0, '0);
    chk("post_rst_not_early", out_valid, 1'b0);
    tick();
    chk_out("post_rst_beat", 16'h00AA, 1'b0, 1'b0, 1'b0);
    tick();

    // Randomized traffic with back-pressure and occasional counter clears.
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 7))
        0: d = 16'h8000;
        1: d = 16'h0000;
        2: d = 16'h8000 | W'($urandom_range(0, 3));
        3: d = 16'h7FFF;
        default: d = W'($urandom);
      endcase
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), d);
      out_ready = $urandom_range(0, 9) < 6;
      cnt_clr   = $urandom_range(0, 31) == 0;
      tick();
    end
    drive(1'b0, 2'd0, '0);
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    chk("drain_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/abs_negate_pipe.md
Name: abs_negate_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit conditional-negate/absolute-value adder.
- Generic WIDTH and pipeline depth; four selectable modes; valid/ready handshake with per-stage stall; most-negative overflow detection; saturating overflow event counter.
- Sits between the convolution accumulator output and the downstream packer/output stage.

Parameters:
- WIDTH, 16, data width in bits (>= 4)
- STAGES, 2, number of pipeline register stages (1..4); also the accept-to-output latency
- CNT_W, 16, width of the overflow event counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  WIDTH  two's-complement operand (sign-magnitude in mode 3)
- in_mode  input  2  0 pass, 1 absolute, 2 negate, 3 sign-magnitude to two's complement
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result
- out_sign  output  1  in_data[WIDTH-1] of the originating beat
- out_cout  output  1  carry out of the final adder bit
- out_ovf  output  1  result not representable (most-negative input in mode 1 or 2)
- cnt_clr  input  1  synchronous clear of ovf_count
- ovf_count  output  CNT_W  saturating count of overflow beats delivered

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all stage valid bits 0; out_valid 0; out_data, out_sign, out_cout and out_ovf 0; ovf_count 0.
  - in_ready is 1 in the first cycle after rst deasserts.
  - Beats in flight when rst asserts are discarded.
- Accept: a beat is accepted when in_valid & in_ready are both high at a rising edge. Deliver: a beat is delivered when out_valid & out_ready are both high.
- Stage 0 arithmetic (combinational, before the first register):
  - Let D = in_data, or {1'b0, in_data[WIDTH-2:0]} in mode 3.
  - Let X = 0 in mode 0, in_data[MSB] in mode 1, 1 in mode 2, in_data[MSB] in mode 3.
  - {cout, result} = (D ^ {WIDTH{X}}) + X. Unsigned add; carry-in is X.
  - ovf = (mode==1 or mode==2) & (in_data == {1'b1, {WIDTH-1{1'b0}}}). In that case result = in_data unchanged.
- Pipeline:
  - STAGES register stages, each holding {valid, result, sign, cout, ovf}.
  - Stage i loads when it is empty or stage i+1 loads in the same cycle. The last stage loads when it is empty or out_ready is high.
  - in_ready is stage 0's load condition (combinational from out_ready through the stage valid bits). Bubbles collapse.
  - Latency is exactly STAGES cycles from accept to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
  - Order is preserved and no beat is lost or duplicated. Output registers hold steady while out_valid=1 and out_ready=0.
- Boundaries:
  - Mode 1 with input 0 gives result 0, cout 0.
  - Mode 2 with input 0 gives result 0, cout 1.
  - Mode 3 with negative zero (MSB set, magnitude 0) gives result 0, cout 1, ovf 0.
  - in_mode is sampled only on accept.
- ovf_count:
  - Increments by 1 on each delivered beat with out_ovf=1 and saturates at all-ones.
  - cnt_clr has priority: if cnt_clr coincides with an increment, the next value is 0.

Optional Feature:
- ABS_SAT_EN defined:
  - An overflow beat returns {1'b0, {WIDTH-1{1'b1}}} (most positive value) instead of the unchanged input.
  - Its out_cout is forced to 0; out_ovf is still 1 and still counted.
- ABS_SAT_EN undefined: behaviour exactly as in Behaviour (wrap: the most-negative input passes through unchanged).

Test Plan:
- WIDTH=16, STAGES=2, out_ready=1, mode 1, input 0xFFFB -> 2 cycles later out_data=0x0005, out_sign=1, out_cout=0, out_ovf=0.
- Mode 2 with input 0x0000, then mode 0 with input 0x1234, back-to-back -> out_data 0x0000 with cout=1, then 0x1234 with cout=0, on consecutive cycles.
- Mode 1, input 0x8000 -> out_data=0x8000, out_ovf=1, ovf_count=1. With ABS_SAT_EN: out_data=0x7FFF, out_cout=0. Assert cnt_clr in the same cycle as a second overflow delivery -> ovf_count=0.
- Mode 3, inputs 0x8003 then 0x8000 -> outputs 0xFFFD, then 0x0000 with cout=1.
- Stall: stream 6 beats with out_ready=0 for 4 cycles -> in_ready drops after 2 beats are held. After release, all 6 beats are delivered in order with no gaps while in_valid stays high.
- Assert rst with 2 beats in flight -> out_valid=0 and ovf_count=0 immediately. After release, the next accepted beat emerges after exactly 2 cycles.
